hub75_bcm_scheduler: RTL and testbench

//   Scan sequencer for a HUB75 RGB LED panel with binary-coded-modulation (BCM) brightness.

---
 rtl/hub75_bcm_scheduler_pkg.sv | 23 ++
 rtl/hub75_bcm_scheduler_if.sv | 12 +
 rtl/hub75_bcm_scheduler_oe_timer.sv | 31 +++
 rtl/hub75_bcm_scheduler.sv | 137 +++++++++++++
 tb/tb_hub75_bcm_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_bcm_scheduler_pkg.sv
// rtl/hub75_bcm_scheduler_pkg.sv - scan FSM state encoding and framebuffer channel indices
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  // channel order inside a packed framebuffer word
  localparam int CH_R0  = 0;
  localparam int CH_G0  = 1;
  localparam int CH_B0  = 2;
  localparam int CH_R1  = 3;
  localparam int CH_G1  = 4;
  localparam int CH_B1  = 5;
  localparam int NUM_CH = 6;

endpackage

// File: rtl/hub75_bcm_scheduler_if.sv
// rtl/hub75_bcm_scheduler_if.sv - framebuffer read port between scheduler and pixel RAM
interface hub75_bcm_scheduler_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 24
);
  logic              fb_rd;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_rdata;

  modport master (output fb_rd, output fb_addr, input fb_rdata);
  modport slave  (input fb_rd, input fb_addr, output fb_rdata);
endinterface

// File: rtl/hub75_bcm_scheduler_oe_timer.sv
// rtl/hub75_bcm_scheduler_oe_timer.sv - display-time down-counter, BASE_OE<<plane cycles per load
module hub75_oe_timer #(
  parameter int BASE_OE  = 8,
  parameter int BCM_BITS = 4,
  parameter int PLANE_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);
  localparam int CNT_W = $clog2(BASE_OE << (BCM_BITS - 1)) + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  // loaded with N-1 so done rises on the N-th cycle after the load
  assign load_val = CNT_W'(BASE_OE << plane) - CNT_W'(1);
  assign done     = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/hub75_bcm_scheduler.sv
// rtl/hub75_bcm_scheduler.sv - HUB75 scan sequencer shifting one BCM bit-plane per row
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 4,
  parameter int BCM_BITS = 4,
  parameter int BASE_OE  = 8,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  hub75_bcm_scheduler_if.master fb,
  output logic [1:0]          mat_r,
  output logic [1:0]          mat_g,
  output logic [1:0]          mat_b,
  output logic [ROW_BITS-1:0] mat_row,
  output logic                mat_clk,
  output logic                mat_lat,
  output logic                mat_oe,
  output logic                frame_start
);
  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
  localparam int DIV_W   = $clog2(CLK_DIV);

  state_t              state, next_state;
  logic [ROW_BITS-1:0] row;
  logic [PLANE_W-1:0]  plane;
  logic [COL_W-1:0]    col;
  logic [DIV_W-1:0]    div_cnt;
  logic [NUM_CH-1:0]   rgb;
  logic                div_last;
  logic                col_last;
  logic                plane_last;
  logic                oe_done;

  assign div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign col_last   = (col == COL_W'(COLS - 1));
  assign plane_last = (plane == PLANE_W'(BCM_BITS - 1));

  hub75_oe_timer #(
    .BASE_OE  (BASE_OE),
    .BCM_BITS (BCM_BITS),
    .PLANE_W  (PLANE_W)
  ) u_oe_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (state == ST_LATCH),
    .plane (plane),
    .done  (oe_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (enable) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_CLK_LO;
      ST_CLK_LO: if (div_last) next_state = ST_CLK_HI;
      ST_CLK_HI: if (div_last) next_state = col_last ? ST_BLANK : ST_FETCH;
      ST_BLANK:  next_state = ST_LATCH;
      ST_LATCH:  next_state = ST_SHOW;
      ST_SHOW:   if (oe_done) next_state = enable ? ST_FETCH : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // decoded from state so reset blanks the panel without waiting for an edge
  assign fb.fb_rd     = (state == ST_FETCH);
  assign fb.fb_addr   = {row, col};
  assign mat_clk      = (state == ST_CLK_HI);
  assign mat_lat      = (state == ST_LATCH);
  assign mat_oe       = (state != ST_SHOW);
  assign frame_start  = (state == ST_FETCH) && (row == '0) && (plane == '0) && (col == '0);
  assign mat_r        = {rgb[CH_R0], rgb[CH_R1]};
  assign mat_g        = {rgb[CH_G0], rgb[CH_G1]};
  assign mat_b        = {rgb[CH_B0], rgb[CH_B1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row     <= '0;
      plane   <= '0;
      col     <= '0;
      div_cnt <= '0;
      rgb     <= '0;
      mat_row <= '0;
    end else begin
      if ((state == ST_CLK_LO || state == ST_CLK_HI) && !div_last) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end

      // read data is valid during the first low-phase cycle only
      if (state == ST_CLK_LO && div_cnt == '0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          rgb[c] <= fb.fb_rdata[c*BCM_BITS + int'(plane)];
        end
      end

      if (state == ST_CLK_HI && div_last) begin
        col <= col_last ? '0 : col + 1'b1;
      end

      if (state == ST_BLANK && plane == '0) begin
        mat_row <= row;
      end

      if (state == ST_IDLE && enable) begin
        row   <= '0;
        plane <= '0;
        col   <= '0;
      end

      if (state == ST_SHOW && oe_done) begin
        if (!enable) begin
          row   <= '0;
          plane <= '0;
        end else if (plane_last) begin
          plane <= '0;
          row   <= row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// tb/tb_hub75_bcm_scheduler.sv - randomized bench against a scan-order reference model
module tb_hub75_bcm_scheduler;
  import hub75_pkg::*;

  localparam int COLS     = 4;
  localparam int ROW_BITS = 2;
  localparam int BCM_BITS = 2;
  localparam int BASE_OE  = 3;
  localparam int CLK_DIV  = 2;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int ADDR_W   = ROW_BITS + $clog2(COLS);
  localparam int DATA_W   = 6 * BCM_BITS;
  localparam int SHIFT_T  = COLS * (1 + 2 * CLK_DIV);
  localparam int FRAME_T  = ROWS * ((SHIFT_T + 2 + BASE_OE) + (SHIFT_T + 2 + (BASE_OE << 1)));

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [1:0] mat_r, mat_g, mat_b;
  logic [ROW_BITS-1:0] mat_row;
  logic mat_clk, mat_lat, mat_oe, frame_start;

  hub75_bcm_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fb ();

  hub75_bcm_scheduler #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .BCM_BITS(BCM_BITS), .BASE_OE(BASE_OE), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb(fb),
    .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b), .mat_row(mat_row),
    .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] mem [ROWS*COLS];

  // one-cycle read latency; garbage otherwise so mistimed sampling shows up
  always @(posedge clk) begin
    if (fb.fb_rd) fb.fb_rdata <= mem[fb.fb_addr];
    else          fb.fb_rdata <= DATA_W'($urandom);
  end

  int cyc = 0;
  logic en_q = 1'b0;
  always @(posedge clk) begin
    cyc++;
    en_q = enable;
  end

  function automatic logic ch_bit(input logic [DATA_W-1:0] w, input int c, input int p);
    logic [DATA_W-1:0] t;
    t = w >> (c * BCM_BITS + p);
    return t[0];
  endfunction

  // reference model: which row/plane/column the panel should be showing next
  int exp_row = 0, exp_plane = 0, ncol = 0, oe_run = 0;
  int last_fs = -1, last_edge = 0, lat_cyc = 0;
  logic prev_clk = 1'b0, prev_oe = 1'b1;
  logic [ROW_BITS-1:0] prev_row = '0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_row = 0; exp_plane = 0; ncol = 0; oe_run = 0; last_fs = -1;
    end else begin
      if (!mat_oe) oe_run++;
      if (!mat_oe && prev_oe) chk("oe_after_lat", cyc - lat_cyc, 1);
      if (mat_oe && !prev_oe) begin
        chk("oe_len", oe_run, BASE_OE << exp_plane);
        oe_run = 0;
        exp_plane++;
        if (exp_plane == BCM_BITS) begin
          exp_plane = 0;
          exp_row = (exp_row + 1) % ROWS;
        end
        if (!en_q) begin
          exp_row = 0; exp_plane = 0; last_fs = -1;
        end
      end
      if (frame_start) begin
        chk("fs_row", exp_row, 0);
        chk("fs_plane", exp_plane, 0);
        chk("fs_addr", fb.fb_addr, 0);
        if (last_fs >= 0) chk("fs_period", cyc - last_fs, FRAME_T);
        last_fs = cyc;
      end
      if (mat_clk) chk("shift_blanked", mat_oe, 1);
      if (mat_clk && !prev_clk) begin
        logic [DATA_W-1:0] w;
        w = mem[exp_row * COLS + ncol];
        chk("rgb_r", mat_r, {ch_bit(w, CH_R0, exp_plane), ch_bit(w, CH_R1, exp_plane)});
        chk("rgb_g", mat_g, {ch_bit(w, CH_G0, exp_plane), ch_bit(w, CH_G1, exp_plane)});
        chk("rgb_b", mat_b, {ch_bit(w, CH_B0, exp_plane), ch_bit(w, CH_B1, exp_plane)});
        if (ncol > 0) chk("clk_gap", cyc - last_edge, 1 + 2 * CLK_DIV);
        last_edge = cyc;
        ncol++;
      end
      if (mat_lat) begin
        chk("lat_cols", ncol, COLS);
        chk("lat_gap", cyc - last_edge, CLK_DIV + 1);
        chk("lat_row", mat_row, exp_row);
        chk("lat_oe", mat_oe, 1);
        lat_cyc = cyc;
        ncol = 0;
      end
      if (mat_row != prev_row) chk("row_chg_oe", mat_oe, 1);
    end
    prev_clk = mat_clk;
    prev_oe  = mat_oe;
    prev_row = mat_row;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oe"}, mat_oe, 1);
    chk({tag, "_lat"}, mat_lat, 0);
    chk({tag, "_clk"}, mat_clk, 0);
    chk({tag, "_rgb"}, {mat_r, mat_g, mat_b}, 0);
    chk({tag, "_row"}, mat_row, 0);
    chk({tag, "_rd"}, fb.fb_rd, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    while (!frame_start && n < 20) begin tick(1); n++; end
    chk({tag, "_fs_seen"}, frame_start, 1);
    chk({tag, "_addr"}, fb.fb_addr, 0);
  endtask

  task automatic restart(input logic [DATA_W-1:0] fill, input logic rnd);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = rnd ? DATA_W'($urandom) : fill;
    enable = 1'b1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = DATA_W'($urandom);
    #2;
    chk_reset_outputs("rst0");
    for (int i = 0; i < 4; i++) begin
      enable = 1'($urandom);
      tick(1);
      chk_reset_outputs("rst_hold");
    end

    // full-intensity plane shifting
    restart('1, 1'b0);
    wait_fs("ones");
    tick(FRAME_T + 5);

    // only r0 bit 1 set: appears only on plane 1, upper half
    restart(DATA_W'(2'b10 << (CH_R0 * BCM_BITS)), 1'b0);
    wait_fs("r0");
    tick(FRAME_T + 5);

    // free run over random pixels
    restart('0, 1'b1);
    wait_fs("free");
    tick(3 * FRAME_T + 10);

    // drop enable mid-plane: row 1, plane 1, column 2
    restart('0, 1'b1);
    n = 0;
    while (!(exp_row == 1 && exp_plane == 1 && ncol == 2) && n < 2 * FRAME_T) begin tick(1); n++; end
    chk("drop_point", (exp_row == 1 && exp_plane == 1 && ncol == 2), 1);
    enable = 1'b0;
    n = 0;
    while (mat_oe && n < 100) begin tick(1); n++; end
    n = 0;
    while (!mat_oe && n < 100) begin tick(1); n++; end
    chk("drop_show_len", n, BASE_OE << 1);
    for (int i = 0; i < 8; i++) begin
      chk("idle_oe", mat_oe, 1);
      chk("idle_rd", fb.fb_rd, 0);
      tick(1);
    end
    enable = 1'b1;
    wait_fs("reen");

    // async reset while the panel is lit
    n = 0;
    while (mat_oe && n < 200) begin tick(1); n++; end
    chk("show_seen", mat_oe, 0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_show");
    tick(3);
    rst = 1'b1;
    wait_fs("post_rst");
    tick(FRAME_T + 5);

    // random enable toggling on random pixels
    restart('0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick($urandom_range(20, 300));
      enable = 1'b0;
      tick($urandom_range(1, 90));
      enable = 1'b1;
    end
    tick(FRAME_T + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
